xpmwrap_tdpram_port_arb: RTL and testbench

XPMWRAP_TDPRAM_PORT_ARB -- requirements
Module: xpmwrap_tdpram_port_arb

---
 rtl/xpmwrap_tdpram_port_arb.sv | 126 ++++++++++++
 tb/tb_xpmwrap_tdpram_port_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xpmwrap_tdpram_port_arb.sv
// Two-requester arbiter in front of one true-dual-port RAM port, with memory clear after reset.
// Define XPMWRAP_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module xpmwrap_tdpram_port_arb #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_regce,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    gnt0, gnt1;
    logic                    xfer, sel1, rd_push;
    logic [READ_LATENCY:1]   vld_pipe;
    logic [READ_LATENCY:1]   id_pipe;

    // state register
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) state <= S_INIT;
        else         state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && clr_cnt == CLR_LAST) state_nxt = S_RUN;
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)              clr_cnt <= '0;
        else if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
    end

`ifdef XPMWRAP_ARB_RR_EN
    logic last_gnt;

    // On contention, the requester that did not win the previous transfer goes first.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_gnt);
        gnt1 = req1_valid & (~req0_valid | ~last_gnt);
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)   last_gnt <= 1'b1;
        else if (xfer) last_gnt <= sel1;
    end
`else
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    // outputs
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = clr_cnt;
        ram_din    = '0;
        init_done  = 1'b0;
        if (state == S_RUN) begin
            init_done  = 1'b1;
            req0_ready = gnt0;
            req1_ready = gnt1;
            ram_en     = gnt0 | gnt1;
            ram_we     = gnt1 ? req1_we    : (gnt0 & req0_we);
            ram_addr   = gnt1 ? req1_addr  : req0_addr;
            ram_din    = gnt1 ? req1_wdata : req0_wdata;
        end
    end

    assign xfer      = req0_ready | req1_ready;
    assign sel1      = req1_ready;
    assign rd_push   = xfer & ~ram_we;
    assign ram_regce = 1'b1;

    // Read tag pipeline: stage READ_LATENCY lines up with ram_dout.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= rd_push;
            id_pipe[1]  <= sel1;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign rsp0_valid = vld_pipe[READ_LATENCY] & ~id_pipe[READ_LATENCY];
    assign rsp1_valid = vld_pipe[READ_LATENCY] &  id_pipe[READ_LATENCY];
    assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
    assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

endmodule

// File: tb/tb_xpmwrap_tdpram_port_arb.sv
// Randomized bench for xpmwrap_tdpram_port_arb against a cycle-level behavioural model.
module tb_xpmwrap_tdpram_port_arb;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clka = 1'b0;
    logic          rsta_n = 1'b0;
    logic          req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata, ram_din, ram_dout;
    logic          ram_en, ram_we, ram_regce, init_done;
    logic [AW-1:0] ram_addr;

    always #5 clka = ~clka;

    xpmwrap_tdpram_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clka(clka), .rsta_n(rsta_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_regce(ram_regce), .ram_dout(ram_dout), .init_done(init_done)
    );

    // RAM port with READ_LATENCY-cycle read path
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] dpipe [RL];
    always @(posedge clka) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        dpipe[0] <= ram_mem[ram_addr];
        end
        for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
    end
    assign ram_dout = dpipe[RL-1];

    // reference model state
    typedef struct {int due; bit id; logic [DW-1:0] data;} rsp_t;
    rsp_t          m_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init = 1'b1;
    int            m_clr = 0;
    bit            m_last = 1'b1;
    int            tcyc = 0;
    int            nvec = 0;
    int            nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, tcyc, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rdy0"}, req0_ready, 0);
        chk({tag, "_rdy1"}, req1_ready, 0);
        chk({tag, "_rsp0"}, rsp0_valid, 0);
        chk({tag, "_rsp1"}, rsp1_valid, 0);
        chk({tag, "_done"}, init_done, 0);
    endtask

    // Called at a falling edge: drive, check, advance the model, wait for next falling edge.
    task automatic cycle(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit            ev0, ev1, wsel;
        logic [DW-1:0] ed, dsel;
        logic [AW-1:0] asel;
        int            g;
        rsp_t          r;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        ev0 = 0; ev1 = 0; ed = '0;
        if (m_q.size() > 0 && m_q[0].due == tcyc) begin
            r = m_q.pop_front();
            ev0 = (r.id == 0); ev1 = (r.id == 1); ed = r.data;
        end
        chk("rsp0_valid", rsp0_valid, ev0);
        chk("rsp1_valid", rsp1_valid, ev1);
        chk("rsp0_rdata", rsp0_rdata, ev0 ? ed : '0);
        chk("rsp1_rdata", rsp1_rdata, ev1 ? ed : '0);
        chk("init_done", init_done, !m_init);
        chk("ram_regce", ram_regce, 1);
        if (m_init) begin
            chk("init_rdy0", req0_ready, 0);
            chk("init_rdy1", req1_ready, 0);
            chk("init_en", ram_en, 1);
            chk("init_we", ram_we, 1);
            chk("init_addr", ram_addr, m_clr);
            chk("init_din", ram_din, 0);
            m_mem[m_clr] = '0;
            if (m_clr == DEPTH-1) m_init = 0;
            m_clr++;
        end else begin
            g = -1;
            if (v0 && v1) begin
`ifdef XPMWRAP_ARB_RR_EN
                g = m_last ? 0 : 1;
`else
                g = 0;
`endif
            end else if (v0) g = 0;
            else if (v1) g = 1;
            chk("req0_ready", req0_ready, g == 0);
            chk("req1_ready", req1_ready, g == 1);
            chk("ram_en", ram_en, g >= 0);
            wsel = (g == 1) ? w1 : w0;
            asel = (g == 1) ? a1 : a0;
            dsel = (g == 1) ? d1 : d0;
            chk("ram_we", ram_we, (g >= 0) && wsel);
            if (g >= 0) begin
                chk("ram_addr", ram_addr, asel);
                if (wsel) begin
                    chk("ram_din", ram_din, dsel);
                    m_mem[asel] = dsel;
                end else begin
                    r.due = tcyc + RL; r.id = (g == 1); r.data = m_mem[asel];
                    m_q.push_back(r);
                end
                m_last = (g == 1);
            end
        end
        tcyc++;
        @(negedge clka);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic rcycle();
        cycle($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        req0_valid = 1; req1_valid = 1;
        rsta_n = 1'b0;
        #1;
        chk_quiet("rst");
        m_q.delete();
        m_init = 1; m_clr = 0; m_last = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clka);
            #1;
            chk_quiet("rst_hold");
        end
        @(negedge clka);
        rsta_n = 1'b1;
    endtask

    initial begin
        @(negedge clka);
        do_reset();
        // memory clear with random traffic that must be held off
        for (int i = 0; i < DEPTH; i++) rcycle();
        idle(1);
        // write then read back through the other requester
        cycle(1, 1, AW'(5), 32'hDEADBEEF, 0, 0, '0, '0);
        cycle(0, 0, '0, '0, 1, 0, AW'(5), '0);
        idle(RL + 1);
        // sustained contention
        for (int i = 0; i < 6; i++) cycle(1, 0, AW'(i), '0, 1, 0, AW'(5), '0);
        idle(RL + 1);
        // back-to-back reads of cleared words
        for (int i = 0; i < 4; i++) cycle(1, 0, AW'(i), '0, 0, 0, '0, '0);
        idle(RL + 1);
        for (int i = 0; i < 300; i++) rcycle();
        idle(RL + 1);
        // reset lands while a read is in flight
        cycle(1, 0, AW'(5), '0, 0, 0, '0, '0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) rcycle();
        for (int i = 0; i < 150; i++) rcycle();
        idle(RL + 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
